// File: rtl/dlx_sim_pkg.sv
// Shared DLX simulation-support definitions: halt trap encoding, DMEM widths and the
// dump controller state type.
package dlx_sim_pkg;

  localparam logic [31:0] TRAP_HALT  = 32'h44000300;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRd,
    StWait,
    StOut,
    StDone
  } dump_state_t;

endpackage

// File: rtl/sat_counter.sv
// Loadable up/down counter that sticks at its limit (all-ones going up, zero going down).
module sat_counter #(
  parameter int unsigned W    = 8,
  parameter bit          DOWN = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;
  logic         at_limit;

  always_comb begin
    at_limit = DOWN ? (count_q == '0) : (count_q == '1);
    count_d  = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !at_limit) begin
      count_d = DOWN ? count_q - W'(1) : count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/trap_dump_controller.sv
// End-of-program monitor: on the halt trap (or cycle budget expiry) freezes fetch, drains the
// pipeline, then streams a window of DMEM words out over a valid/ready port.
module trap_dump_controller
  import dlx_sim_pkg::*;
#(
  parameter logic [31:0]     TRAP_WORD      = TRAP_HALT,
  parameter int unsigned     DRAIN_CYCLES   = 5,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter int unsigned     NUM_WORDS      = 3,
  parameter int unsigned     ADDR_W         = 32,
  parameter int unsigned     TIMEOUT_CYCLES = 25000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              halt_req,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [31:0]       dump_data,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       cycle_count
);

  localparam longint unsigned LAST_OFF = 64'(NUM_WORDS - 1) * 64'd4;
  localparam bit ADDR_FITS = (ADDR_W >= 64) ? (BASE_ADDR <= (~64'd0 - LAST_OFF))
                                            : ((BASE_ADDR + LAST_OFF) < (64'd1 << ADDR_W));

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
    $error("DRAIN_CYCLES must be in 1..255");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_words
    $error("NUM_WORDS must be in 1..256");
  end
  if (ADDR_W < 2 || ADDR_W > 64) begin : g_bad_addr_w
    $error("ADDR_W must be in 2..64");
  end
  if ((BASE_ADDR % 4) != 0) begin : g_bad_align
    $error("BASE_ADDR must be word aligned");
  end
  if (!ADDR_FITS) begin : g_bad_window
    $error("dump window exceeds the address space");
  end

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [7:0]        LAST_IDX   = 8'(NUM_WORDS - 1);
  localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [31:0]       TMO_AT     = 32'(TIMEOUT_CYCLES - 1);
  localparam bit                TMO_EN     = (TIMEOUT_CYCLES != 0);

  dump_state_t       state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic              timed_out_q, timed_out_d;
  logic              drain_load, drain_en;
  logic [7:0]        drain_cnt;
  logic              trap_hit, tmo_hit;
  logic [ADDR_W-1:0] word_addr;

  sat_counter #(
    .W    (32),
    .DOWN (1'b0)
  ) u_cycle_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (1'b0),
    .load_val (32'd0),
    .en       (1'b1),
    .count    (cycle_count)
  );

  // Loaded with DRAIN_CYCLES-1 on entry so DRAIN lasts exactly DRAIN_CYCLES cycles.
  sat_counter #(
    .W    (8),
    .DOWN (1'b1)
  ) u_drain_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .en       (drain_en),
    .count    (drain_cnt)
  );

  assign trap_hit  = instr_valid && (instr == TRAP_WORD);
  assign tmo_hit   = TMO_EN && (cycle_count == TMO_AT);
  assign word_addr = BASE + ADDR_W'({idx_q, 2'b00});

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    timed_out_d = timed_out_q;
    drain_load  = 1'b0;
    drain_en    = 1'b0;
    halt_req    = 1'b1;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    dump_valid  = 1'b0;
    dump_addr   = '0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        halt_req = 1'b0;
        // A real trap takes priority, so a coincident budget expiry is not reported.
        if (trap_hit) begin
          state_d    = StDrain;
          drain_load = 1'b1;
        end else if (tmo_hit) begin
          state_d     = StDrain;
          drain_load  = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      StDrain: begin
        if (drain_cnt == 8'd0) begin
          state_d = StRd;
        end else begin
          drain_en = 1'b1;
        end
      end
      StRd: begin
        mem_rd   = 1'b1;
        mem_addr = word_addr;
        state_d  = StWait;
      end
      StWait: begin
        data_d  = mem_rdata;
        state_d = StOut;
      end
      StOut: begin
        dump_valid = 1'b1;
        dump_addr  = word_addr;
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRd;
          end
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 8'd0;
      data_q      <= 32'd0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign dump_data = data_q;
  assign timed_out = timed_out_q;

endmodule
